// File: rtl/pixl_mac_engine.sv
// Framed byte-command pixel engine: parses LOAD/MUL/DOT frames from the UART
// receive FIFO and streams saturated per-lane or dot-product results back out.
module pixl_mac_engine #(
   parameter int LANES   = 4,
   parameter int SHIFT   = 8,
   parameter int TIMEOUT = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_empty,
   input  logic [7:0] rx_data,
   output logic       rd,
   input  logic       tx_full,
   output logic [7:0] tx_data,
   output logic       wr,
   output logic       busy,
   output logic       weights_valid,
   output logic       frame_err
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int SW = 16 + $clog2(LANES);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARG  = 3'd1,
      S_WAIT = 3'd2,
      S_EXEC = 3'd3,
      S_TX   = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_rd;
   logic          r_wr;
   logic          r_busy;
   logic          r_wv;
   logic          r_ferr;
   logic [7:0]    r_tx_data;
   logic [7:0]    r_opcode;
   logic [IW-1:0] r_arg_idx;
   logic [IW-1:0] r_tx_idx;
   logic [IW-1:0] r_tx_last;
   logic [TW-1:0] r_tmo;
   logic [7:0]    r_pix [LANES];
   logic [7:0]    r_w   [LANES];
   logic [7:0]    r_res [LANES];
   logic [7:0]    w_lane [LANES];
   logic [15:0]   w_prod [LANES];
   logic [SW-1:0] w_dot;
   logic          w_hold;
   logic          w_pop;
   logic          w_push;
   logic          w_tmo_hit;
   logic          w_err_resp;

   function automatic logic [7:0] sat_shift(input logic [SW-1:0] v);
      logic [SW-1:0] s;
      s = v >> SHIFT;
      if (|s[SW-1:8]) begin
         return 8'hFF;
      end else begin
         return s[7:0];
      end
   endfunction

   // The clock after any pop or push is the FIFO flag-settling cycle.
   assign w_hold     = r_rd | r_wr;
   assign w_err_resp = (r_opcode > 8'h02) || ((r_opcode != 8'h00) && !r_wv);

   // Per-lane products, their saturated bytes, and the full-width dot sum.
   always_comb begin
      w_dot = '0;
      for (int i = 0; i < LANES; i++) begin
         w_prod[i] = 16'(r_pix[i]) * 16'(r_w[i]);
         w_lane[i] = sat_shift(SW'(w_prod[i]));
         w_dot     = w_dot + SW'(w_prod[i]);
      end
   end

   // Next-state and pop/push/timeout decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_push      = 1'b0;
      w_tmo_hit   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_hold && !rx_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = (rx_data > 8'h02) ? S_WAIT : S_ARG;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ARG: begin
            if (!w_hold && !rx_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = (r_arg_idx == IW'(LANES - 1)) ? S_WAIT : S_ARG;
            end else if (r_tmo == TW'(TIMEOUT - 1)) begin
               w_tmo_hit   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_ARG;
            end
         end
         S_WAIT: w_state_nxt = S_EXEC;
         S_EXEC: w_state_nxt = S_TX;
         S_TX: begin
            if (!w_hold && !tx_full) begin
               w_push      = 1'b1;
               w_state_nxt = (r_tx_idx == r_tx_last) ? S_IDLE : S_TX;
            end else begin
               w_state_nxt = S_TX;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Control state and registered strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_busy    <= 1'b0;
         r_ferr    <= 1'b0;
         r_tx_data <= 8'h00;
         r_tmo     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rd    <= w_pop;
         r_wr    <= w_push;
         r_busy  <= (w_state_nxt != S_IDLE) || w_push;
         r_ferr  <= w_tmo_hit || ((r_state == S_WAIT) && w_err_resp);
         if (w_push) begin
            r_tx_data <= r_res[r_tx_idx];
         end
         // Idle counter only runs while a frame is partially received.
         if (w_pop || (r_state != S_ARG)) begin
            r_tmo <= '0;
         end else begin
            r_tmo <= r_tmo + 1'b1;
         end
      end
   end

   // Frame capture, weight storage and response staging.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_opcode  <= 8'h00;
         r_arg_idx <= '0;
         r_tx_idx  <= '0;
         r_tx_last <= '0;
         r_wv      <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            r_pix[i] <= 8'h00;
            r_w[i]   <= 8'h00;
            r_res[i] <= 8'h00;
         end
      end else begin
         if (w_pop && (r_state == S_IDLE)) begin
            r_opcode  <= rx_data;
            r_arg_idx <= '0;
         end else if (w_pop && (r_state == S_ARG)) begin
            r_pix[r_arg_idx] <= rx_data;
            r_arg_idx        <= r_arg_idx + 1'b1;
         end
         if (r_state == S_EXEC) begin
            r_tx_idx  <= '0;
            r_tx_last <= '0;
            if (w_err_resp) begin
               r_res[0] <= 8'hEE;
            end else begin
               case (r_opcode)
                  8'h00: begin
                     for (int i = 0; i < LANES; i++) begin
                        r_w[i] <= r_pix[i];
                     end
                     r_wv     <= 1'b1;
                     r_res[0] <= 8'hA5;
                  end
                  8'h01: begin
                     for (int i = 0; i < LANES; i++) begin
                        r_res[i] <= w_lane[i];
                     end
                     r_tx_last <= IW'(LANES - 1);
                  end
                  8'h02:   r_res[0] <= sat_shift(w_dot);
                  default: r_res[0] <= 8'hEE;
               endcase
            end
         end else if (w_push) begin
            r_tx_idx <= r_tx_idx + 1'b1;
         end
      end
   end

   assign rd            = r_rd;
   assign wr            = r_wr;
   assign tx_data       = r_tx_data;
   assign busy          = r_busy;
   assign weights_valid = r_wv;
   assign frame_err     = r_ferr;

endmodule

// File: doc/pixl_mac_engine.md
# pixl_mac_engine

Parametrised pixel multiply/dot-product engine sitting between the `uart` byte FIFOs and the host link. It parses framed byte commands from the UART receive FIFO, holds a per-lane weight vector, computes per-lane scaled products or a saturated dot product, and streams response bytes back through the UART transmit FIFO. It supersedes the fixed 4-lane, 9-byte pixel block with configurable lane count, scaling, a dot-product mode, acknowledgements, and inter-byte timeout recovery.

## Interface
- `LANES`, 4, number of pixel/weight lanes (1..16); argument bytes per frame.
- `SHIFT`, 8, right shift applied to products/sums before saturation (0..15).
- `TIMEOUT`, 100000, idle clocks allowed between bytes of one frame before it is discarded (≥2).

- `clk` in 1 system clock, rising edge.
- `rst` in 1 asynchronous, active-high reset.
- `rx_empty` in 1 UART receive FIFO empty; `rx_data` valid when 0.
- `rx_data` in 8 UART receive FIFO head byte.
- `rd` out 1 one-clock pop strobe to the receive FIFO.
- `tx_full` in 1 UART transmit FIFO full.
- `tx_data` out 8 byte to transmit; valid while `wr`=1.
- `wr` out 1 one-clock push strobe to the transmit FIFO.
- `busy` out 1 high from opcode pop until last response byte pushed.
- `weights_valid` out 1 high once a weight load has completed.
- `frame_err` out 1 one-clock pulse on timeout, unknown opcode, or compute without weights.

## Operation
- Frame = opcode byte, then LANES argument bytes (opcodes 0x00–0x02 only). Lane i = i-th argument byte.
- 0x00 LOAD: store arguments into weight registers (all lanes updated together after last byte), set `weights_valid`, respond 0xA5.
- 0x01 MUL: per lane `r[i] = min(255, (pix[i]*w[i]) >> SHIFT)`, 16-bit unsigned product; respond LANES bytes, lane 0 first.
- 0x02 DOT: `s = sum(pix[i]*w[i])`, width 16+clog2(LANES), no overflow; respond one byte `min(255, s >> SHIFT)`.
- Any other opcode: no arguments consumed, respond 0xEE, pulse `frame_err`.
- 0x01/0x02 with `weights_valid`=0: arguments still consumed, respond single 0xEE, pulse `frame_err`.
- States: IDLE → (pop opcode) → ARG → (LANES pops) → EXEC → TX → IDLE. Every pop/push is followed by one HOLD clock in which `rx_empty`/`tx_full` are ignored (FIFO flag update latency).
- Pop: in IDLE/ARG with `rx_empty`=0, capture `rx_data` and assert `rd` for exactly one clock. Push: in TX with `tx_full`=0, drive `tx_data` and assert `wr` for exactly one clock; `tx_full`=1 stalls indefinitely without loss.
- Timeout: in ARG, counter resets on each pop; reaching TIMEOUT idle clocks discards partial frame (weights unchanged), pulses `frame_err`, returns to IDLE, no response. No timeout in IDLE or TX.
- Receive bytes arriving during EXEC/TX stay in the FIFO; not popped until IDLE.

## Timing
- Reset values: `rd`=0, `wr`=0, `tx_data`=0x00, `busy`=0, `weights_valid`=0, `frame_err`=0, weights all 0, state IDLE, timeout counter 0.
- All outputs registered. Consecutive `rd` (or `wr`) pulses separated by ≥1 low clock; max one byte per 2 clocks.
- With `rx_empty`=0 continuously, a frame is consumed in 2·(LANES+1) clocks.
- First `wr` asserted 3 clocks after the `rd` pulse of the final argument byte (HOLD, EXEC, TX) when `tx_full`=0; error response for unknown opcode likewise 3 clocks after opcode `rd`.
- `frame_err` pulses in the EXEC clock for error responses, in the clock after expiry for timeout.
- `rd` and `wr` never high in the same clock.
- `rst` mid-frame or mid-response: immediate return to reset values; in-flight response bytes not sent.

## Test plan
- LOAD 00 80 40 FF 01 -> one `wr` with 0xA5, `weights_valid`=1, `busy` low after push.
- Then MUL 01 FF 10 02 FF -> `wr` bytes 0x7F, 0x04, 0x01, 0x00 in order; first `wr` 3 clocks after last `rd`.
- DOT 02 FF 10 02 FF (same weights) -> single 0x86; weights all 0xFF with pixels all 0xFF -> saturated 0xFF.
- After reset, MUL 01 + 4 bytes -> 5 pops, single 0xEE, one `frame_err` pulse; opcode 0x07 -> 1 pop, 0xEE, `frame_err`, next byte treated as opcode.
- `TIMEOUT`=16: send 00 11 22 then stall 16 clocks -> `frame_err` pulse, no `wr`, weights unchanged; following full LOAD accepted normally.
- Hold `tx_full`=1 for 50 clocks during MUL response -> `wr` low throughout, all 4 bytes emitted unchanged after release; assert `rst` mid-response -> all outputs at reset values, no further `wr`.
